hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage CPU (PC / BF0 / BF1 / BF2 / BF3). It keeps a shadow scoreboard of register writes in flight in EX, MEM and WB. It stalls PC and BF0 and injects a bubble into BF1 on read-after-write hazards. It flushes wrong-path instructions when a branch resolves taken in MEM, and keeps saturating stall and flush counters for performance checks.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush counters.

Ports:
- clk_CPU  in  1  CPU clock; all state updates on the rising edge.
- rst_CPU  in  1  reset, synchronous, active-high.
- op_ID  in  6  opcode of the instruction held in BF0.
- rs_ID  in  5  rs field from BF0.
- rt_ID  in  5  rt field from BF0.
- rd_ID  in  5  rd field from BF0.
- brTaken_MEM  in  1  branch flag AND zero flag from BF2 (branch resolved taken).
- pcWrite  out  1  1 = PC loads next value; 0 = PC holds.
- bf0Write  out  1  1 = BF0 loads; 0 = BF0 holds.
- bf1Bubble  out  1  1 = BF1 loads all-zero EX/M/WB controls.
- flush_BF0  out  1  clear BF0 to NOP at this edge.
- flush_BF1  out  1  clear BF1 controls at this edge.
- flush_BF2  out  1  clear BF2 controls at this edge.
- stalled  out  1  FSM in STALL.
- stallCnt  out  CNT_W  stall cycles since reset, saturating.
- flushCnt  out  CNT_W  taken-branch flushes since reset, saturating.

## Operation
- Decode of op_ID:
  - op=0 (R-type): reads rs and rt; writes rd.
  - op=35 (lw): reads rs; writes rt.
  - op=43 (sw): reads rs and rt; no write.
  - op=4 (beq): reads rs and rt; no write.
  - Any other opcode is a NOP: no reads, no write.
- Internal idValid register:
  - Cleared by reset and by a flush.
  - Set when BF0 loads a non-flushed instruction.
  - The ID instruction is considered only when idValid=1.
- Scoreboard: three entries, sbEX, sbMEM and sbWB. Each entry holds {wr, dest[4:0]}.
- Hazard (combinational): idValid=1 AND some entry has wr=1, dest≠0, and dest equals a register the ID instruction reads.
  - WB counts as a hazard source: the register bank does not bypass same-cycle writes.
  - Register $0 never causes a hazard.
- FSM with two states, RUN and STALL:
  - RUN→STALL when hazard=1 and brTaken_MEM=0.
  - STALL→RUN when hazard=0 or brTaken_MEM=1.
  - STALL→STALL while hazard persists.
- Outputs in RUN with no hazard: pcWrite=1, bf0Write=1, bf1Bubble=0, all flush_* = 0.
- Hazard, with no branch taken:
  - pcWrite=0, bf0Write=0, bf1Bubble=1.
  - sbEX loads an invalid entry; sbMEM←sbEX; sbWB←sbMEM.
- No hazard, no branch taken: sbEX ← {wr, dest} of the ID instruction; entries shift as above.
- brTaken_MEM=1 (priority over hazard):
  - flush_BF0=flush_BF1=flush_BF2=1, pcWrite=1 (PC takes the branch target), bf0Write=1, bf1Bubble=0.
  - At the edge: sbEX←invalid, sbMEM←invalid, sbWB←sbMEM; idValid←0; state←RUN.
- Counters:
  - stallCnt +1 on each edge where hazard=1 and brTaken_MEM=0.
  - flushCnt +1 on each edge where brTaken_MEM=1.
  - Both saturate at 2^CNT_W−1.

## Timing
- Hazard, stall and flush outputs are combinational from the current inputs and registered state. They act at the same rising edge (zero-cycle latency).
- The scoreboard, FSM, idValid and counters update on the rising edge.
- Worst-case stall is 3 cycles: the producer sits in EX when the consumer reaches ID.
- Stall length: 3 / 2 / 1 cycles when the producer is 1 / 2 / 3 instructions ahead.
- While rst_CPU=1:
  - Outputs: pcWrite=0, bf0Write=0, bf1Bubble=1, flush_*=0, stalled=0.
  - At the edge: scoreboard invalid, idValid=0, state RUN, counters 0.
  - Reset asserted mid-STALL takes effect at the next edge.
  - First cycle after release: pcWrite=1.
- Hazard and branch taken in the same cycle: the flush wins, no stall is counted, and the FSM goes to RUN.

## Test plan
- Independent stream: add $3,$1,$2; add $4,$5,$6; sw $7,0($8) -> pcWrite=1 every cycle, stallCnt=0.
- lw $2,0($1) then add $3,$2,$2 -> stalled=1 and bf1Bubble=1 for exactly 3 cycles, stallCnt=3; add enters EX after lw writes back.
- add $0,$1,$1 then add $3,$0,$0 -> no stall; lw $5 then two NOPs then add $6,$5,$1 -> exactly 1 stall cycle.
- beq resolving taken (brTaken_MEM=1) while the ID instruction has a hazard -> all flush_*=1 and pcWrite=1 that cycle, next cycle state RUN, flushCnt=1, stallCnt unchanged.
- rst_CPU high during the 2nd cycle of a 3-cycle stall -> next cycle stalled=0, counters 0, scoreboard empty; after release, pcWrite=1.
- CNT_W=4, 20 consecutive stall cycles -> stallCnt holds at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow scoreboard of writes in EX/MEM/WB, RAW stall
// with BF1 bubble, taken-branch flush of BF0..BF2, and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk_CPU,
    input  logic             rst_CPU,
    input  logic [5:0]       op_ID,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic [4:0]       rd_ID,
    input  logic             brTaken_MEM,
    output logic             pcWrite,
    output logic             bf0Write,
    output logic             bf1Bubble,
    output logic             flush_BF0,
    output logic             flush_BF1,
    output logic             flush_BF2,
    output logic             stalled,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;

    typedef enum logic {RUN, STALL} state_t;

    state_t     state, state_nxt;
    logic       id_valid;
    logic [5:0] sb_ex, sb_mem, sb_wb;   // {wr, dest[4:0]}
    logic       reads_rs, reads_rt, wr_id;
    logic [4:0] dest_id;
    logic       hazard;

    always_comb begin
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        wr_id    = 1'b0;
        dest_id  = 5'd0;
        case (op_ID)
            OP_RTYPE: begin reads_rs = 1'b1; reads_rt = 1'b1; wr_id = 1'b1; dest_id = rd_ID; end
            OP_LW:    begin reads_rs = 1'b1; wr_id = 1'b1; dest_id = rt_ID; end
            OP_SW:    begin reads_rs = 1'b1; reads_rt = 1'b1; end
            OP_BEQ:   begin reads_rs = 1'b1; reads_rt = 1'b1; end
            default:  ;
        endcase
    end

    function automatic logic sb_hit(input logic [5:0] entry, input logic [4:0] reg_id);
        return entry[5] && (entry[4:0] != 5'd0) && (entry[4:0] == reg_id);
    endfunction

    // WB is a hazard source too: the register bank does not forward same-cycle writes.
    always_comb begin
        hazard = id_valid && (
            (reads_rs && (sb_hit(sb_ex, rs_ID) || sb_hit(sb_mem, rs_ID) || sb_hit(sb_wb, rs_ID))) ||
            (reads_rt && (sb_hit(sb_ex, rt_ID) || sb_hit(sb_mem, rt_ID) || sb_hit(sb_wb, rt_ID))));
    end

    always_comb begin
        pcWrite   = 1'b1;
        bf0Write  = 1'b1;
        bf1Bubble = 1'b0;
        flush_BF0 = 1'b0;
        flush_BF1 = 1'b0;
        flush_BF2 = 1'b0;
        state_nxt = RUN;
        if (rst_CPU) begin
            pcWrite   = 1'b0;
            bf0Write  = 1'b0;
            bf1Bubble = 1'b1;
        end else if (brTaken_MEM) begin
            flush_BF0 = 1'b1;
            flush_BF1 = 1'b1;
            flush_BF2 = 1'b1;
        end else if (hazard) begin
            pcWrite   = 1'b0;
            bf0Write  = 1'b0;
            bf1Bubble = 1'b1;
            state_nxt = STALL;
        end
    end

    assign stalled = (state == STALL) && !rst_CPU;

    always_ff @(posedge clk_CPU) begin
        if (rst_CPU) begin
            state    <= RUN;
            id_valid <= 1'b0;
            sb_ex    <= '0;
            sb_mem   <= '0;
            sb_wb    <= '0;
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            state <= state_nxt;
            sb_wb <= sb_mem;
            if (brTaken_MEM) begin
                // Instructions younger than the branch are squashed, so their writes vanish.
                sb_ex    <= '0;
                sb_mem   <= '0;
                id_valid <= 1'b0;
                if (flushCnt != '1) flushCnt <= flushCnt + CNT_W'(1);
            end else begin
                sb_mem <= sb_ex;
                if (hazard) begin
                    sb_ex <= '0;
                    if (stallCnt != '1) stallCnt <= stallCnt + CNT_W'(1);
                end else begin
                    sb_ex    <= {wr_id & id_valid, dest_id};
                    id_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hand-computed expectations checked by immediate assertions.
module tb_hazard_ctrl;

    localparam logic [5:0] R   = 6'd0;
    localparam logic [5:0] LW  = 6'd35;
    localparam logic [5:0] SW  = 6'd43;
    localparam logic [5:0] NOP = 6'd63;

    logic        clk_CPU = 1'b0;
    logic        rst_CPU;
    logic [5:0]  op_ID;
    logic [4:0]  rs_ID, rt_ID, rd_ID;
    logic        brTaken_MEM;
    logic        pcWrite, bf0Write, bf1Bubble, flush_BF0, flush_BF1, flush_BF2, stalled;
    logic [15:0] stallCnt, flushCnt;
    logic        pcWrite4, bf0Write4, bf1Bubble4, flush_BF04, flush_BF14, flush_BF24, stalled4;
    logic [3:0]  stallCnt4, flushCnt4;

    int pass_cnt = 0;
    int total_cnt = 0;
    int bubbles;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk_CPU(clk_CPU), .rst_CPU(rst_CPU), .op_ID(op_ID), .rs_ID(rs_ID), .rt_ID(rt_ID),
        .rd_ID(rd_ID), .brTaken_MEM(brTaken_MEM), .pcWrite(pcWrite), .bf0Write(bf0Write),
        .bf1Bubble(bf1Bubble), .flush_BF0(flush_BF0), .flush_BF1(flush_BF1),
        .flush_BF2(flush_BF2), .stalled(stalled), .stallCnt(stallCnt), .flushCnt(flushCnt)
    );

    hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk_CPU(clk_CPU), .rst_CPU(rst_CPU), .op_ID(op_ID), .rs_ID(rs_ID), .rt_ID(rt_ID),
        .rd_ID(rd_ID), .brTaken_MEM(brTaken_MEM), .pcWrite(pcWrite4), .bf0Write(bf0Write4),
        .bf1Bubble(bf1Bubble4), .flush_BF0(flush_BF04), .flush_BF1(flush_BF14),
        .flush_BF2(flush_BF24), .stalled(stalled4), .stallCnt(stallCnt4), .flushCnt(flushCnt4)
    );

    always #5 clk_CPU = ~clk_CPU;

    // Present one ID instruction, then wait to mid-cycle where outputs are sampled.
    task automatic apply(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic br);
        op_ID = op; rs_ID = rs; rt_ID = rt; rd_ID = rd; brTaken_MEM = br;
        @(negedge clk_CPU);
    endtask

    task automatic tick;
        @(posedge clk_CPU);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        // reset
        rst_CPU = 1'b1;
        apply(NOP, 0, 0, 0, 0);
        chk("rst_pcWrite", pcWrite, 0);
        chk("rst_bf0Write", bf0Write, 0);
        chk("rst_bf1Bubble", bf1Bubble, 1);
        chk("rst_flush", {flush_BF0, flush_BF1, flush_BF2}, 0);
        chk("rst_stalled", stalled, 0);
        tick;
        rst_CPU = 1'b0;
        apply(NOP, 0, 0, 0, 0);
        chk("post_rst_pcWrite", pcWrite, 1);
        chk("post_rst_stallCnt", stallCnt, 0);
        chk("post_rst_flushCnt", flushCnt, 0);
        tick;

        // independent stream
        apply(R, 1, 2, 3, 0);  chk("ind0_pcWrite", pcWrite, 1); tick;
        apply(R, 5, 6, 4, 0);  chk("ind1_pcWrite", pcWrite, 1); tick;
        apply(SW, 8, 7, 0, 0); chk("ind2_pcWrite", pcWrite, 1); tick;

        // lw $2 then add $3,$2,$2: 3-cycle stall
        apply(LW, 1, 2, 0, 0);
        chk("ind_stallCnt", stallCnt, 0);
        chk("lw_pcWrite", pcWrite, 1);
        tick;
        apply(R, 2, 2, 3, 0);
        chk("s1_bubble", bf1Bubble, 1); chk("s1_pcWrite", pcWrite, 0);
        chk("s1_bf0Write", bf0Write, 0); chk("s1_stalled", stalled, 0);
        tick;
        apply(R, 2, 2, 3, 0); chk("s2_bubble", bf1Bubble, 1); chk("s2_stalled", stalled, 1); tick;
        apply(R, 2, 2, 3, 0); chk("s3_bubble", bf1Bubble, 1); chk("s3_stalled", stalled, 1); tick;
        apply(R, 2, 2, 3, 0);
        chk("s4_bubble", bf1Bubble, 0); chk("s4_pcWrite", pcWrite, 1);
        chk("s4_stalled", stalled, 1); chk("s4_stallCnt", stallCnt, 3);
        tick;
        apply(NOP, 0, 0, 0, 0); chk("s5_stalled", stalled, 0); chk("s5_stallCnt", stallCnt, 3); tick;

        // $0 never hazards; lw, two NOPs, dependent add -> 1 stall
        apply(R, 1, 1, 0, 0); chk("r0a_pcWrite", pcWrite, 1); tick;
        apply(R, 0, 0, 3, 0); chk("r0b_pcWrite", pcWrite, 1); tick;
        apply(LW, 1, 5, 0, 0); tick;
        apply(NOP, 0, 0, 0, 0); tick;
        apply(NOP, 0, 0, 0, 0); tick;
        apply(R, 5, 1, 6, 0); chk("wb_bubble", bf1Bubble, 1); chk("wb_stallCnt", stallCnt, 3); tick;
        apply(R, 5, 1, 6, 0); chk("wb_go_pcWrite", pcWrite, 1); chk("wb_stallCnt2", stallCnt, 4); tick;

        // taken branch together with hazard: flush wins
        apply(LW, 1, 7, 0, 0); tick;
        apply(R, 7, 7, 8, 1);
        chk("br_flush", {flush_BF0, flush_BF1, flush_BF2}, 3'b111);
        chk("br_pcWrite", pcWrite, 1); chk("br_bf0Write", bf0Write, 1);
        chk("br_bubble", bf1Bubble, 0);
        tick;
        apply(R, 7, 7, 8, 0);
        chk("br_next_stalled", stalled, 0); chk("br_flushCnt", flushCnt, 1);
        chk("br_stallCnt", stallCnt, 4); chk("br_idinvalid_pcWrite", pcWrite, 1);
        tick;
        apply(R, 7, 7, 8, 0); chk("br_sb_cleared", bf1Bubble, 0); tick;

        // reset during 2nd cycle of a stall
        apply(LW, 1, 9, 0, 0); tick;
        apply(R, 9, 9, 10, 0); chk("rs1_bubble", bf1Bubble, 1); tick;
        rst_CPU = 1'b1;
        apply(R, 9, 9, 10, 0);
        chk("rs2_stalled", stalled, 0); chk("rs2_pcWrite", pcWrite, 0);
        tick;
        rst_CPU = 1'b0;
        apply(NOP, 0, 0, 0, 0);
        chk("rs3_stalled", stalled, 0); chk("rs3_stallCnt", stallCnt, 0);
        chk("rs3_flushCnt", flushCnt, 0); chk("rs3_pcWrite", pcWrite, 1);
        tick;
        apply(R, 9, 9, 10, 0); chk("rs_sb_empty", pcWrite, 1); tick;

        // seven lw/add pairs: 21 stalls, 4-bit counter saturates at 15
        for (int r = 0; r < 7; r++) begin
            apply(LW, 1, 2, 0, 0); tick;
            bubbles = 0;
            for (int c = 0; c < 10; c++) begin
                apply(R, 2, 2, 3, 0);
                if (!bf1Bubble) break;
                bubbles++;
                tick;
            end
            chk("pair_bubbles", bubbles, 3);
            tick;
        end
        apply(NOP, 0, 0, 0, 0);
        chk("sat_stallCnt16", stallCnt, 21);
        chk("sat_stallCnt4", stallCnt4, 15);
        tick;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
